// File: rtl/program_loader.sv
// Serial program loader: parses A5/LEN/payload/checksum frames from a byte
// stream, writes payload bytes to program memory and holds the core meanwhile.
module program_loader #(
  parameter int MEM_BYTES      = 1024,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        write_enable,
  output logic [7:0]  write_data,
  output logic [31:0] write_address,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int IW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAXLEN = 17'(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CHECK
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      sum_q, sum_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            we_q, we_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [IW-1:0]   waddr_q, waddr_d;
  logic            hold_q, hold_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            acc;
  logic            timeout;
  logic [15:0]     lenw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      tcnt_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      tcnt_q  <= tcnt_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign acc  = rx_valid & rx_ready;
  assign lenw = {rx_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // Idle counter only runs inside a frame and saturates at the limit
    if (state_q == IDLE || acc)
      tcnt_d = '0;
    else if (tcnt_q == TMAX)
      tcnt_d = tcnt_q;
    else
      tcnt_d = tcnt_q + 1'b1;
    timeout = (state_q != IDLE) && !acc && (tcnt_q >= TLAST);
    unique case (state_q)
      IDLE: begin
        if (acc && rx_data == 8'hA5) begin
          state_d = LEN_LO;
          sum_d   = '0;
          idx_d   = '0;
          hold_d  = 1'b1;
        end
      end
      LEN_LO: begin
        if (acc) begin
          len_d   = {8'h00, rx_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (acc) begin
          len_d = lenw;
          if (lenw == 16'd0 || {1'b0, lenw} > MAXLEN) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (acc) begin
          we_d    = 1'b1;
          wdata_d = rx_data;
          waddr_d = idx_q;
          sum_d   = sum_q + rx_data;
          idx_d   = idx_q + 1'b1;
          if (16'(idx_q) == len_q - 16'd1)
            state_d = CHECK;
        end
      end
      CHECK: begin
        if (acc) begin
          state_d = IDLE;
          if (rx_data == sum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    rx_ready      = rst_n;
    write_enable  = we_q;
    write_data    = wdata_q;
    write_address = 32'(waddr_q);
    cpu_hold      = hold_q;
    load_done     = done_q;
    load_error    = err_q;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 1024, meaning the program memory size in bytes and the maximum legal payload length.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum idle cycles between accepted bytes inside a frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port rx_valid, input, 1 bit: a byte is offered on rx_data.
REQ-006 The block SHALL have port rx_data, input, 8 bits: the offered byte.
REQ-007 The block SHALL have port rx_ready, output, 1 bit: the block accepts the offered byte this cycle.
REQ-008 The block SHALL have port write_enable, output, 1 bit: program memory byte write strobe.
REQ-009 The block SHALL have port write_data, output, 8 bits: byte to write.
REQ-010 The block SHALL have port write_address, output, 32 bits: byte address of the write.
REQ-011 The block SHALL have port cpu_hold, output, 1 bit: holds the core while memory contents are being replaced or are invalid.
REQ-012 The block SHALL have port load_done, output, 1 bit: one-cycle pulse on a successful load.
REQ-013 The block SHALL have port load_error, output, 1 bit: one-cycle pulse on a failed load.

Function
REQ-014 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-015 rx_ready SHALL be 1 in every cycle with rst_n=1, and 0 in any cycle with rst_n=0.
REQ-016 The frame format SHALL be: sync 0xA5, LEN low byte, LEN high byte, LEN payload bytes, then one checksum byte.
REQ-017 The FSM SHALL have states IDLE, LEN_LO, LEN_HI, DATA and CHECK.
REQ-018 In IDLE, accepting 0xA5 SHALL go to LEN_LO; any other accepted byte SHALL be discarded and the FSM SHALL stay in IDLE.
REQ-019 LEN_LO SHALL go to LEN_HI, and LEN_HI SHALL go to DATA on acceptance.
REQ-020 If the assembled 16-bit LEN is 0 or greater than MEM_BYTES, the FSM SHALL go to IDLE and pulse load_error in the cycle after the LEN high byte is accepted.
REQ-021 cpu_hold SHALL rise in the cycle after the sync byte is accepted.
REQ-022 In DATA, the n-th accepted payload byte (n from 0) SHALL produce, in the following cycle only, write_enable=1, write_data equal to that byte and write_address=n.
REQ-023 write_enable SHALL be 0 in all other cycles, and write_address and write_data SHALL hold their last value when write_enable is 0.
REQ-024 The checksum SHALL be the 8-bit running sum, modulo 256, of all payload bytes, and it SHALL be cleared when the sync byte is accepted.
REQ-025 After LEN payload bytes are accepted, the FSM SHALL go to CHECK, and the checksum byte SHALL be accepted in CHECK.
REQ-026 If the checksum matches, the next cycle SHALL pulse load_done and clear cpu_hold; if it does not match, the next cycle SHALL pulse load_error and keep cpu_hold at 1. In both cases the FSM SHALL return to IDLE.
REQ-027 cpu_hold SHALL remain 1 after any error until a later load completes successfully.
REQ-028 In LEN_LO, LEN_HI, DATA or CHECK, TIMEOUT_CYCLES consecutive cycles with no accepted byte SHALL pulse load_error in the next cycle and return the FSM to IDLE.
REQ-029 The idle counter SHALL restart on every accepted byte and SHALL saturate; it SHALL never wrap.
REQ-030 load_done and load_error SHALL never both be 1 in the same cycle.
REQ-031 A sync byte 0xA5 received outside IDLE SHALL be treated as ordinary data and SHALL NOT restart the frame.
REQ-032 The payload byte index SHALL be sized to hold MEM_BYTES-1, and write_address SHALL be zero-extended to 32 bits.

Reset
REQ-033 With rst_n=0 at a clock edge, the FSM SHALL be in IDLE and rx_ready, write_enable, write_data, write_address, cpu_hold, load_done, load_error, the checksum and all counters SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame without any error pulse, and cpu_hold SHALL be 0 after reset.

Verification
REQ-035 The bench SHALL drive A5 04 00 13 00 00 00 13, expect writes (0,0x13) (1,0x00) (2,0x00) (3,0x00), a load_done pulse, and cpu_hold back to 0.
REQ-036 The bench SHALL drive the same frame with checksum 0x14, expect load_error, no load_done, and cpu_hold=1; a following valid frame SHALL clear cpu_hold.
REQ-037 The bench SHALL drive A5 01 04 (LEN=1025) and expect load_error, no write_enable, and the FSM back in IDLE.
REQ-038 The bench SHALL drive bytes 00 FF then a valid frame, expect the leading bytes ignored, and expect the payload written from address 0.
REQ-039 With TIMEOUT_CYCLES=16, the bench SHALL send A5 02 00 11 and then stall, expect load_error exactly 17 cycles after the last accepted byte, and expect cpu_hold=1.
REQ-040 The bench SHALL assert rst_n=0 during DATA and expect all outputs at 0 with no error pulse; after release, a valid frame SHALL load normally.
